// File: rtl/control_pkg.sv
// Shared definitions for the multicycle RV32I control FSM: state encoding,
// opcode classes and the default instruction ROM image.
package control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_DONE
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ADDI  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] INSN_ADD   = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] INSN_LW    = 32'h0000_2183; // lw   x3,0(x0)
  localparam logic [31:0] INSN_SW    = 32'h0020_2223; // sw   x2,4(x0)
  localparam logic [31:0] INSN_BEQ   = 32'h0000_0463; // beq  x0,x0,8
  localparam logic [31:0] INSN_ECALL = 32'h0000_0073; // ecall

  // First eight words of the program; any deeper word holds ROM_FILL_DEFAULT.
  localparam logic [0:7][31:0] ROM_IMAGE_DEFAULT = '{
    INSN_ADDI, INSN_ADD, INSN_LW, INSN_SW, INSN_BEQ, INSN_ECALL, INSN_ECALL, INSN_ECALL
  };
  localparam logic [31:0] ROM_FILL_DEFAULT = INSN_ECALL;

  // Opcodes that take the EXECUTE path; everything else is SYSTEM or a NOP.
  function automatic logic is_exec_class(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_IALU) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/control_rom.sv
// Combinational instruction ROM, ROM_DEPTH x 32. Words 0-7 come from IMAGE,
// deeper words from FILL.
module control_rom
  import control_pkg::*;
#(
  parameter int               ROM_DEPTH = 8,
  parameter logic [0:7][31:0] IMAGE     = ROM_IMAGE_DEFAULT,
  parameter logic [31:0]      FILL      = ROM_FILL_DEFAULT
) (
  input  logic [$clog2(ROM_DEPTH)-1:0] addr,
  output logic [31:0]                  data
);

  logic [31:0] mem [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_word
    if (i < 8) begin : g_img
      assign mem[i] = IMAGE[i];
    end else begin : g_fill
      assign mem[i] = FILL;
    end
  end

  assign data = mem[addr];

endmodule

// File: rtl/control.sv
// Multicycle RV32I control FSM with no datapath: walks the stored program
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction class and
// parks in DONE on ecall. Branches are never taken.
// Optional feature: define CONTROL_WATCHDOG_EN to force DONE after
// WATCHDOG_CYCLES active cycles.
module control
  import control_pkg::*;
#(
  parameter int               ROM_DEPTH       = 8,
  parameter int               WATCHDOG_CYCLES = 64,
  parameter logic [0:7][31:0] ROM_IMAGE       = ROM_IMAGE_DEFAULT,
  parameter logic [31:0]      ROM_FILL        = ROM_FILL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int AW = $clog2(ROM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, ir_q, rom_data;
  logic        pc_inc, ir_load, done_d, wd_hit;
  logic [6:0]  opcode;
  logic        unused_ir;

  assign opcode    = ir_q[6:0];
  assign unused_ir = ^ir_q[31:7];

  control_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .IMAGE     (ROM_IMAGE),
    .FILL      (ROM_FILL)
  ) u_rom (
    .addr (pc_q[AW+1:2]),
    .data (rom_data)
  );

`ifdef CONTROL_WATCHDOG_EN
  localparam int CW = $clog2(WATCHDOG_CYCLES + 1);
  logic [CW-1:0] wd_cnt_q;
  logic          active;

  assign active = (state_q != ST_IDLE) && (state_q != ST_DONE);
  // Fires in the last of WATCHDOG_CYCLES active cycles so DONE follows directly.
  assign wd_hit = active && (wd_cnt_q == CW'(WATCHDOG_CYCLES - 1));

  // Count every cycle spent running the program.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        wd_cnt_q <= '0;
    else if (active) wd_cnt_q <= wd_cnt_q + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: route by opcode class held in IR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:
        if (is_exec_class(opcode))   state_d = ST_EXECUTE;
        else if (opcode == OP_SYSTEM) state_d = ST_DONE;
        else                          state_d = ST_FETCH;
      ST_EXECUTE:
        if (opcode == OP_LOAD || opcode == OP_STORE) state_d = ST_MEMORY;
        else if (opcode == OP_BRANCH)                state_d = ST_FETCH;
        else                                         state_d = ST_WRITEBACK;
      ST_MEMORY:    state_d = (opcode == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_DONE:      state_d = ST_DONE;
      default:      state_d = ST_IDLE;
    endcase
    if (wd_hit) state_d = ST_DONE;
  end

  // Outputs: IR load, pc advance on instruction completion (or NOP), done.
  always_comb begin
    ir_load = (state_q == ST_FETCH);
    done_d  = (state_q == ST_DONE);
    pc_inc  = 1'b0;
    case (state_q)
      ST_DECODE:    pc_inc = !is_exec_class(opcode) && (opcode != OP_SYSTEM);
      ST_EXECUTE:   pc_inc = (opcode == OP_BRANCH);
      ST_MEMORY:    pc_inc = (opcode == OP_STORE);
      ST_WRITEBACK: pc_inc = 1'b1;
      default:      pc_inc = 1'b0;
    endcase
  end

  // pc, IR and the registered done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
      ir_q <= '0;
      done <= 1'b0;
    end else begin
      if (ir_load) ir_q <= rom_data;
      if (pc_inc)  pc_q <= pc_q + 32'd4;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_control.sv
// Directed bench for control. Three instances share clk/rst/start:
//   dut     - default ROM
//   dut_nop - word 0 illegal (0xFFFFFFFF), rest default
//   dut_wd  - ROM all addi, WATCHDOG_CYCLES=10
// Edge N is the edge that samples start=1; DONE is entered after the state
// count of the program, and done follows one edge later.
module tb_control;
  import control_pkg::*;

  localparam logic [0:7][31:0] NOP_IMAGE = '{
    32'hFFFF_FFFF, 32'h0010_8133, 32'h0000_2183, 32'h0020_2223,
    32'h0000_0463, 32'h0000_0073, 32'h0000_0073, 32'h0000_0073
  };
  localparam logic [0:7][31:0] ADDI_IMAGE = '{8{32'h0050_0093}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic done_def, done_nop, done_wd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  control dut (.clk(clk), .rst(rst), .start(start), .done(done_def));

  control #(.ROM_IMAGE(NOP_IMAGE)) dut_nop (
    .clk(clk), .rst(rst), .start(start), .done(done_nop));

  control #(.WATCHDOG_CYCLES(10), .ROM_IMAGE(ADDI_IMAGE), .ROM_FILL(32'h0050_0093)) dut_wd (
    .clk(clk), .rst(rst), .start(start), .done(done_wd));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Launch: drive start for exactly one sampling edge (edge N).
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    #1;
    vectors++;
    if (dut.state_q !== ST_IDLE || done_def !== 1'b0 || dut.pc_q !== 32'd0 || dut.ir_q !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_vals: state=%0d done=%b pc=%h ir=%h, want state=0 done=0 pc=0 ir=0",
               dut.state_q, done_def, dut.pc_q, dut.ir_q);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (dut.state_q !== ST_IDLE || done_def !== 1'b0 || done_nop !== 1'b0 || done_wd !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold[%0d]: state=%0d done=%b/%b/%b, want IDLE and done 0",
                 k, dut.state_q, done_def, done_nop, done_wd);
      end
    end
  endtask

  // Default program: 4+4+5+4+3+2 = 22 states -> DONE at N+22, done at N+23.
  // NOP image: addi(4) replaced by NOP(2) -> 20 states -> done at N+21.
  task automatic test_default_run();
    logic exp_wd;
    do_reset();
    launch();
    for (int k = 1; k <= 24; k++) begin
      tick();
`ifdef CONTROL_WATCHDOG_EN
      exp_wd = (k >= 11);
`else
      exp_wd = 1'b0;
`endif
      vectors++;
      if (done_def !== (k >= 23)) begin
        miscompares++;
        $display("FAIL default_done@N+%0d: got %b want %b", k, done_def, (k >= 23));
      end
      vectors++;
      if (done_nop !== (k >= 21)) begin
        miscompares++;
        $display("FAIL nop_done@N+%0d: got %b want %b", k, done_nop, (k >= 21));
      end
      vectors++;
      if (done_wd !== exp_wd) begin
        miscompares++;
        $display("FAIL wd_done@N+%0d: got %b want %b", k, done_wd, exp_wd);
      end
    end
    // DONE absorbs with start toggling.
    for (int k = 0; k < 6; k++) begin
      start = k[0];
      tick();
      vectors++;
      if (done_def !== 1'b1 || dut.state_q !== ST_DONE) begin
        miscompares++;
        $display("FAIL done_absorb[%0d]: done=%b state=%0d want 1/DONE", k, done_def, dut.state_q);
      end
    end
    start = 1'b0;
  endtask

  // lw is word 2: FETCH at N+8 .. WRITEBACK at N+12, next FETCH at N+13 with pc 12.
  task automatic test_lw_states();
    state_e exp_seq [5] = '{ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK};
    do_reset();
    launch();
    for (int k = 1; k <= 7; k++) tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (dut.state_q !== exp_seq[k] || dut.pc_q !== 32'd8) begin
        miscompares++;
        $display("FAIL lw_state[%0d]: state=%0d pc=%h want state=%0d pc=00000008",
                 k, dut.state_q, dut.pc_q, exp_seq[k]);
      end
    end
    tick();
    vectors++;
    if (dut.state_q !== ST_FETCH || dut.pc_q !== 32'd12) begin
      miscompares++;
      $display("FAIL lw_next: state=%0d pc=%h want FETCH pc=0000000c", dut.state_q, dut.pc_q);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    launch();
    for (int k = 1; k <= 10; k++) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (dut.state_q !== ST_IDLE || done_def !== 1'b0 || dut.pc_q !== 32'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: state=%0d done=%b pc=%h want IDLE 0 0", dut.state_q, done_def, dut.pc_q);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (dut.state_q !== ST_IDLE) begin
        miscompares++;
        $display("FAIL midrun_wait[%0d]: state=%0d want IDLE", k, dut.state_q);
      end
    end
    launch();
    for (int k = 1; k <= 22; k++) tick();
    vectors++;
    if (done_def !== 1'b0) begin
      miscompares++;
      $display("FAIL rerun_done@N+22: got %b want 0", done_def);
    end
    tick();
    vectors++;
    if (done_def !== 1'b1) begin
      miscompares++;
      $display("FAIL rerun_done@N+23: got %b want 1", done_def);
    end
  endtask

  // All-addi program never hits ecall: only the watchdog can end it.
  task automatic test_watchdog();
    logic exp;
    do_reset();
    launch();
    for (int k = 1; k <= 200; k++) begin
      tick();
`ifdef CONTROL_WATCHDOG_EN
      exp = (k >= 11);
`else
      exp = 1'b0;
`endif
      vectors++;
      if (done_wd !== exp) begin
        miscompares++;
        $display("FAIL watchdog@N+%0d: got %b want %b", k, done_wd, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_lw_states();
    test_reset_midrun();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
